// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time program loader feeding the PATP main store
//
// Accepts a byte stream over in_valid/in_ready, writes DEPTH bytes into the
// main store at sequential addresses and releases the core (core_run) once
// the whole image has arrived.
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require one trailing
// checksum byte after the image; the load succeeds only when
// (sum of image bytes + checksum byte) mod 2^DATA_W == 0.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   start     request a new load (level-sampled in IDLE/DONE/ERROR)
//   in_valid  upstream byte valid
//   in_data   upstream byte
//   in_ready  loader accepts a byte (decoded from state)
//   ms_we     main-store write strobe, one cycle per byte
//   ms_addr   main-store write address
//   ms_wdata  main-store write data
//   core_run  core may execute
//   busy      load in progress
//   done      last load completed successfully
//   error     last load failed its checksum (0 without the checksum feature)

module prog_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ms_we,
  output logic [ADDR_W-1:0] ms_addr,
  output logic [DATA_W-1:0] ms_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHECK = 3'd2,
`endif
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              accept;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] chk_total;

  // Running sum plus the checksum byte currently on the bus, mod 2^DATA_W.
  assign chk_total = sum_q + in_data;
  assign in_ready  = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
  assign in_ready  = (state_q == S_LOAD);
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (in_valid && (cnt_q == LAST)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (in_valid) state_d = (chk_total == '0) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE:  if (start) state_d = S_LOAD;
      S_ERROR: if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ms_we    <= 1'b0;
      ms_addr  <= '0;
      ms_wdata <= '0;
      core_run <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_we   <= 1'b0;
      if ((state_q == S_LOAD) && accept) begin
        ms_we    <= 1'b1;
        ms_addr  <= cnt_q;
        ms_wdata <= in_data;
        // Natural wrap returns the counter to 0 on the final image byte.
        cnt_q    <= cnt_q + 1'b1;
      end else if ((state_q == S_IDLE) || (state_q == S_DONE) ||
                   (state_q == S_ERROR)) begin
        cnt_q <= '0;
      end
      // Status flags follow the next state so they line up with the state.
`ifdef PROG_LOADER_CHECKSUM_EN
      busy     <= (state_d == S_LOAD) || (state_d == S_CHECK);
`else
      busy     <= (state_d == S_LOAD);
`endif
      done     <= (state_d == S_DONE);
      core_run <= (state_d == S_DONE);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      error <= 1'b0;
    end else begin
      error <= (state_d == S_ERROR);
      if ((state_q == S_LOAD) && accept) begin
        sum_q <= sum_q + in_data;
      end else if ((state_q == S_IDLE) || (state_q == S_DONE) ||
                   (state_q == S_ERROR)) begin
        sum_q <= '0;
      end
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
